// File: rtl/dram_axi_bridge_pkg.sv
// Shared types and AXI constants for the DRAM-to-AXI bridge.
// Lane steering is selected by the DRAM_AXI_LANE_STEER_EN macro (see axi_lane_mux).
package dram_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR    = 3'd1,
        ST_WRESP = 3'd2,
        ST_RD    = 3'd3,
        ST_RDATA = 3'd4
    } state_t;

    localparam int AXI_DATA_W = 128;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;
    localparam int AXI_LANES  = AXI_DATA_W / 32;

    localparam logic [2:0] AXI_SIZE_4B       = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
    localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;

endpackage

// File: rtl/dram_axi_bridge_if.sv
// AXI4 channel bundle between the bridge (master) and MIG_BLOCK (slave).
// Handshake: a transfer happens on a rising clk edge where valid && ready; valid never waits on ready.
interface dram_axi_bridge_if #(parameter int ADDR_W = 32);
    import dram_axi_pkg::*;

    logic [0:0]            awid;
    logic [ADDR_W-1:0]     awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awlock;
    logic [3:0]            awcache;
    logic [2:0]            awprot;
    logic [3:0]            awqos;
    logic [3:0]            awregion;
    logic                  awvalid;
    logic                  awready;

    logic [AXI_DATA_W-1:0] wdata;
    logic [AXI_STRB_W-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    logic [0:0]            bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    logic [0:0]            arid;
    logic [ADDR_W-1:0]     araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic [3:0]            arqos;
    logic [3:0]            arregion;
    logic                  arvalid;
    logic                  arready;

    logic [0:0]            rid;
    logic [AXI_DATA_W-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/dram_axi_bridge_lane_mux.sv
// Combinational placement of a 32-bit word into the 128-bit AXI bus and selection back out.
// DRAM_AXI_LANE_STEER_EN steers by addr[3:2]; otherwise everything lives in lane 0.
module axi_lane_mux
    import dram_axi_pkg::*;
(
    input  logic [1:0]            lane_i,
    input  logic [31:0]           wdata_i,
    input  logic [3:0]            we_i,
    input  logic [AXI_DATA_W-1:0] rdata_i,
    output logic [AXI_DATA_W-1:0] wdata_o,
    output logic [AXI_STRB_W-1:0] wstrb_o,
    output logic [31:0]           rdata_o
);

`ifdef DRAM_AXI_LANE_STEER_EN
    always_comb begin
        wdata_o = '0;
        wstrb_o = '0;
        rdata_o = '0;
        for (int i = 0; i < AXI_LANES; i++) begin
            if (lane_i == 2'(i)) begin
                wdata_o[i*32 +: 32] = wdata_i;
                wstrb_o[i*4 +: 4]   = we_i;
                rdata_o             = rdata_i[i*32 +: 32];
            end
        end
    end
`else
    logic unused_lane_bits;

    assign wdata_o = {{(AXI_DATA_W-32){1'b0}}, wdata_i};
    assign wstrb_o = {{(AXI_STRB_W-4){1'b0}}, we_i};
    assign rdata_o = rdata_i[31:0];
    assign unused_lane_bits = ^{lane_i, rdata_i[AXI_DATA_W-1:32]};
`endif

endmodule

// File: rtl/dram_axi_bridge.sv
// Single-outstanding bridge from the CPU DRAM port to a 128-bit AXI4 slave (MIG_BLOCK).
// Lane steering is enabled with DRAM_AXI_LANE_STEER_EN; the default build uses lane 0 only.
module dram_axi_bridge
    import dram_axi_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dram_oe,
    input  logic [31:0]       dram_addr,
    input  logic [31:0]       dram_wdata,
    input  logic [3:0]        dram_we,
    output logic [31:0]       dram_rdata,
    output logic              dram_valid,
    output logic              dram_err,
    output logic              dram_busy,
    output state_t            dbg_state_o,
    dram_axi_bridge_if.master m_axi
);

    state_t                state_q, state_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            we_q, we_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;

    logic                  aw_fire, w_fire;
    logic [AXI_DATA_W-1:0] bus_wdata;
    logic [AXI_STRB_W-1:0] bus_wstrb;
    logic [31:0]           lane_rdata;
    logic                  unused_axi;

    axi_lane_mux u_lane_mux (
        .lane_i  (addr_q[3:2]),
        .wdata_i (wdata_q),
        .we_i    (we_q),
        .rdata_i (m_axi.rdata),
        .wdata_o (bus_wdata),
        .wstrb_o (bus_wstrb),
        .rdata_o (lane_rdata)
    );

    assign aw_fire = m_axi.awvalid && m_axi.awready;
    assign w_fire  = m_axi.wvalid && m_axi.wready;

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        rdata_d   = rdata_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dram_we != 4'h0 || dram_oe) begin
                    addr_d    = ADDR_W'(dram_addr);
                    wdata_d   = dram_wdata;
                    we_d      = dram_we;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = (dram_we != 4'h0) ? ST_WR : ST_RD;
                end
            end
            ST_WR: begin
                // AW and W complete independently; either may finish first or both together.
                aw_done_d = aw_done_q || aw_fire;
                w_done_d  = w_done_q || w_fire;
                if (aw_done_d && w_done_d) begin
                    state_d = ST_WRESP;
                end
            end
            ST_WRESP: begin
                if (m_axi.bvalid) begin
                    err_d   = (m_axi.bresp != AXI_RESP_OKAY);
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                if (m_axi.arready) begin
                    state_d = ST_RDATA;
                end
            end
            ST_RDATA: begin
                if (m_axi.rvalid) begin
                    rdata_d = lane_rdata;
                    valid_d = 1'b1;
                    err_d   = (m_axi.rresp != AXI_RESP_OKAY);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= '0;
            rdata_q   <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            rdata_q   <= rdata_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign dram_rdata  = rdata_q;
    assign dram_valid  = valid_q;
    assign dram_err    = err_q;
    assign dram_busy   = (state_q != ST_IDLE);
    assign dbg_state_o = state_q;

    // Valids come only from registered state, so they never depend on ready.
    assign m_axi.awvalid  = (state_q == ST_WR) && !aw_done_q;
    assign m_axi.wvalid   = (state_q == ST_WR) && !w_done_q;
    assign m_axi.bready   = (state_q == ST_WRESP);
    assign m_axi.arvalid  = (state_q == ST_RD);
    assign m_axi.rready   = (state_q == ST_RDATA);

    assign m_axi.awid     = 1'b0;
    assign m_axi.awaddr   = addr_q;
    assign m_axi.awlen    = 8'd0;
    assign m_axi.awsize   = AXI_SIZE_4B;
    assign m_axi.awburst  = AXI_BURST_INCR;
    assign m_axi.awlock   = 1'b0;
    assign m_axi.awcache  = AXI_CACHE_DEFAULT;
    assign m_axi.awprot   = 3'd0;
    assign m_axi.awqos    = 4'd0;
    assign m_axi.awregion = 4'd0;

    assign m_axi.wdata    = bus_wdata;
    assign m_axi.wstrb    = bus_wstrb;
    assign m_axi.wlast    = 1'b1;

    assign m_axi.arid     = 1'b0;
    assign m_axi.araddr   = addr_q;
    assign m_axi.arlen    = 8'd0;
    assign m_axi.arsize   = AXI_SIZE_4B;
    assign m_axi.arburst  = AXI_BURST_INCR;
    assign m_axi.arlock   = 1'b0;
    assign m_axi.arcache  = AXI_CACHE_DEFAULT;
    assign m_axi.arprot   = 3'd0;
    assign m_axi.arqos    = 4'd0;
    assign m_axi.arregion = 4'd0;

    assign unused_axi = ^{m_axi.bid, m_axi.rid, m_axi.rlast};

endmodule

// File: tb/tb_dram_axi_bridge.sv
// Directed bench for dram_axi_bridge against a registered-ready AXI slave model with memory.
// Honours DRAM_AXI_LANE_STEER_EN for the lane-steering expectations.
module tb_dram_axi_bridge;
    import dram_axi_pkg::*;

    logic        clk;
    logic        rst;
    logic        dram_oe;
    logic [31:0] dram_addr;
    logic [31:0] dram_wdata;
    logic [3:0]  dram_we;
    logic [31:0] dram_rdata;
    logic        dram_valid;
    logic        dram_err;
    logic        dram_busy;
    state_t      dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    dram_axi_bridge_if #(.ADDR_W(32)) axi_if ();

    dram_axi_bridge #(.ADDR_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .dram_oe     (dram_oe),
        .dram_addr   (dram_addr),
        .dram_wdata  (dram_wdata),
        .dram_we     (dram_we),
        .dram_rdata  (dram_rdata),
        .dram_valid  (dram_valid),
        .dram_err    (dram_err),
        .dram_busy   (dram_busy),
        .dbg_state_o (dbg_state),
        .m_axi       (axi_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- slave model ----------------
    logic [127:0] mem [0:255];
    int           w_delay = 0;
    logic [1:0]   b_resp_cfg = 2'b00;
    logic [1:0]   r_resp_cfg = 2'b00;
    logic         aw_got, w_got;
    int           w_cnt;
    logic [31:0]  s_awaddr, s_araddr;
    logic [127:0] s_wdata;
    logic [15:0]  s_wstrb;
    logic [7:0]   s_awlen;
    logic [2:0]   s_awsize;
    logic [1:0]   s_awburst;
    logic [3:0]   s_awcache;
    logic         s_wlast;
    logic [31:0]  wr_addr;
    logic [127:0] wr_data;
    logic [15:0]  wr_strb;
    int           n_valid = 0;
    int           n_err   = 0;
    int           n_b     = 0;

    wire aw_fire = axi_if.awvalid && axi_if.awready;
    wire w_fire  = axi_if.wvalid && axi_if.wready;
    wire b_fire  = axi_if.bvalid && axi_if.bready;
    wire ar_fire = axi_if.arvalid && axi_if.arready;
    wire r_fire  = axi_if.rvalid && axi_if.rready;

    assign axi_if.bid   = 1'b0;
    assign axi_if.rid   = 1'b0;
    assign axi_if.rlast = 1'b1;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
    end

    always @(posedge clk) begin
        if (dram_valid) n_valid <= n_valid + 1;
        if (dram_err)   n_err   <= n_err + 1;
        if (b_fire)     n_b     <= n_b + 1;
    end

    always @(posedge clk) begin
        if (rst) begin
            axi_if.awready <= 1'b0;
            axi_if.wready  <= 1'b0;
            axi_if.bvalid  <= 1'b0;
            axi_if.bresp   <= 2'b00;
            axi_if.arready <= 1'b0;
            axi_if.rvalid  <= 1'b0;
            axi_if.rresp   <= 2'b00;
            axi_if.rdata   <= '0;
            aw_got         <= 1'b0;
            w_got          <= 1'b0;
            w_cnt          <= 0;
        end else begin
            axi_if.awready <= axi_if.awvalid && !axi_if.awready && !aw_got;
            if (aw_fire) begin
                aw_got    <= 1'b1;
                s_awaddr  <= axi_if.awaddr;
                s_awlen   <= axi_if.awlen;
                s_awsize  <= axi_if.awsize;
                s_awburst <= axi_if.awburst;
                s_awcache <= axi_if.awcache;
            end
            if (axi_if.wvalid && !axi_if.wready && !w_got) begin
                if (w_cnt == w_delay) axi_if.wready <= 1'b1;
                else                  w_cnt <= w_cnt + 1;
            end else begin
                axi_if.wready <= 1'b0;
            end
            if (w_fire) begin
                w_got   <= 1'b1;
                w_cnt   <= 0;
                s_wdata <= axi_if.wdata;
                s_wstrb <= axi_if.wstrb;
                s_wlast <= axi_if.wlast;
            end
            if ((aw_got || aw_fire) && (w_got || w_fire) && !axi_if.bvalid) begin
                wr_addr = aw_fire ? axi_if.awaddr : s_awaddr;
                wr_data = w_fire ? axi_if.wdata : s_wdata;
                wr_strb = w_fire ? axi_if.wstrb : s_wstrb;
                for (int b = 0; b < 16; b++) begin
                    if (wr_strb[b]) mem[wr_addr[11:4]][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
                axi_if.bvalid <= 1'b1;
                axi_if.bresp  <= b_resp_cfg;
                aw_got        <= 1'b0;
                w_got         <= 1'b0;
            end
            if (b_fire) axi_if.bvalid <= 1'b0;
            axi_if.arready <= axi_if.arvalid && !axi_if.arready;
            if (ar_fire) begin
                s_araddr      <= axi_if.araddr;
                axi_if.rvalid <= 1'b1;
                axi_if.rdata  <= mem[axi_if.araddr[11:4]];
                axi_if.rresp  <= r_resp_cfg;
            end
            if (r_fire) axi_if.rvalid <= 1'b0;
        end
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we,
                            output int lat, output logic aw3, output logic w3, output logic err);
        dram_addr  = a;
        dram_wdata = d;
        dram_we    = we;
        dram_oe    = 1'b0;
        @(posedge clk); #1;
        dram_we = 4'h0;
        lat = 1; aw3 = 1'b0; w3 = 1'b0; err = 1'b0;
        while (dram_busy && lat < 100) begin
            if (lat == 3) begin
                aw3 = axi_if.awvalid;
                w3  = axi_if.wvalid;
            end
            @(posedge clk); #1;
            lat++;
            err |= dram_err;
        end
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output int lat,
                           output logic err);
        dram_addr = a;
        dram_oe   = 1'b1;
        dram_we   = 4'h0;
        @(posedge clk); #1;
        dram_oe = 1'b0;
        lat = 1;
        while (!dram_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        d   = dram_rdata;
        err = dram_err;
    endtask

    // ---------------- stimulus ----------------
    int          lat;
    logic        aw3, w3, err;
    logic [31:0] rd;
    int          base_valid, base_err, base_b;

    initial begin
        rst = 1'b1; dram_oe = 1'b0; dram_addr = '0; dram_wdata = '0; dram_we = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy",    dram_busy,      1'b0);
        check_eq("rst_valid",   dram_valid,     1'b0);
        check_eq("rst_err",     dram_err,       1'b0);
        check_eq("rst_rdata",   dram_rdata,     32'h0);
        check_eq("rst_awvalid", axi_if.awvalid, 1'b0);
        check_eq("rst_wvalid",  axi_if.wvalid,  1'b0);
        check_eq("rst_arvalid", axi_if.arvalid, 1'b0);
        check_eq("rst_bready",  axi_if.bready,  1'b0);
        check_eq("rst_rready",  axi_if.rready,  1'b0);
        check_eq("rst_state",   128'(dbg_state), 128'(ST_IDLE));
        rst = 1'b0;

        // Reset in the middle of a write that the slave stalls on W.
        w_delay = 20;
        base_err = n_err; base_valid = n_valid;
        dram_addr = 32'h300; dram_wdata = 32'h55AA55AA; dram_we = 4'hF;
        @(posedge clk); #1;
        dram_we = 4'h0;
        @(posedge clk); #1;
        check_eq("mid_wvalid", axi_if.wvalid, 1'b1);
        check_eq("mid_busy",   dram_busy,     1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("mrst_awvalid", axi_if.awvalid, 1'b0);
        check_eq("mrst_wvalid",  axi_if.wvalid,  1'b0);
        check_eq("mrst_busy",    dram_busy,      1'b0);
        check_eq("mrst_state",   128'(dbg_state), 128'(ST_IDLE));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        w_delay = 0;
        @(posedge clk); #1;
        check_eq("mrst_no_err",   n_err,   base_err);
        check_eq("mrst_no_valid", n_valid, base_valid);

        // Full-word write then read.
        do_write(32'h100, 32'hDEADBEEF, 4'hF, lat, aw3, w3, err);
        check_eq("wr_lat",     lat,       4);
        check_eq("wr_err",     err,       1'b0);
        check_eq("wr_aw3",     aw3,       1'b0);
        check_eq("wr_w3",      w3,        1'b0);
        check_eq("wr_awaddr",  s_awaddr,  32'h100);
        check_eq("wr_awlen",   s_awlen,   8'd0);
        check_eq("wr_awsize",  s_awsize,  3'b010);
        check_eq("wr_awburst", s_awburst, 2'b01);
        check_eq("wr_awcache", s_awcache, 4'b0011);
        check_eq("wr_wlast",   s_wlast,   1'b1);
        check_eq("wr_wstrb",   s_wstrb,   16'h000F);
        check_eq("wr_wdata",   s_wdata[31:0], 32'hDEADBEEF);

        base_valid = n_valid;
        do_read(32'h100, rd, lat, err);
        check_eq("rd_data",   rd,       32'hDEADBEEF);
        check_eq("rd_lat",    lat,      4);
        check_eq("rd_err",    err,      1'b0);
        check_eq("rd_araddr", s_araddr, 32'h100);
        @(posedge clk); #1;
        check_eq("rd_pulse_end", dram_valid, 1'b0);
        check_eq("rd_hold",      dram_rdata, 32'hDEADBEEF);
        check_eq("rd_one_pulse", n_valid,    base_valid + 1);

        // Byte write merges into the existing word.
        base_valid = n_valid;
        do_write(32'h100, 32'h0000AB00, 4'b0010, lat, aw3, w3, err);
        check_eq("bw_lat",      lat,     4);
        check_eq("bw_no_valid", n_valid, base_valid);
        do_read(32'h100, rd, lat, err);
        check_eq("bw_rd_data", rd, 32'hDEADABEF);

        // Slave holds wready off 3 cycles after awready.
        w_delay = 3;
        base_b = n_b;
        do_write(32'h200, 32'h12345678, 4'hF, lat, aw3, w3, err);
        check_eq("dly_lat",   lat, 7);
        check_eq("dly_aw3",   aw3, 1'b0);
        check_eq("dly_w3",    w3,  1'b1);
        check_eq("dly_one_b", n_b, base_b + 1);
        check_eq("dly_state", 128'(dbg_state), 128'(ST_IDLE));
        w_delay = 0;
        do_read(32'h200, rd, lat, err);
        check_eq("dly_rd_data", rd, 32'h12345678);

        // Read error response: valid and err together.
        r_resp_cfg = 2'b10;
        base_err = n_err;
        do_read(32'h100, rd, lat, err);
        r_resp_cfg = 2'b00;
        check_eq("rerr_lat",   lat,        4);
        check_eq("rerr_valid", dram_valid, 1'b1);
        check_eq("rerr_err",   err,        1'b1);
        check_eq("rerr_data",  rd,         32'hDEADABEF);
        @(posedge clk); #1;
        check_eq("rerr_pulse", n_err - base_err, 1);

        // Write error response: err pulse, no valid pulse.
        b_resp_cfg = 2'b10;
        base_valid = n_valid;
        do_write(32'h200, 32'hCAFEF00D, 4'hF, lat, aw3, w3, err);
        b_resp_cfg = 2'b00;
        check_eq("werr_err",      err,     1'b1);
        check_eq("werr_no_valid", n_valid, base_valid);

        // Lane placement for a word at addr[3:2]=2.
        do_write(32'h108, 32'h11223344, 4'hF, lat, aw3, w3, err);
`ifdef DRAM_AXI_LANE_STEER_EN
        check_eq("lane_wstrb", s_wstrb,         16'h0F00);
        check_eq("lane_wdata", s_wdata[95:64],  32'h11223344);
`else
        check_eq("lane_wstrb", s_wstrb,         16'h000F);
        check_eq("lane_wdata", s_wdata[31:0],   32'h11223344);
`endif
        do_read(32'h108, rd, lat, err);
        check_eq("lane_rd_data", rd, 32'h11223344);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
